rf_wport_arb: RTL and testbench

RF_WPORT_ARB -- requirements
Module: rf_wport_arb

---
 rtl/rf_wport_arb_if.sv | 47 ++++
 rtl/rf_wport_arb.sv | 133 +++++++++++++
 tb/tb_rf_wport_arb.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/rf_wport_arb_if.sv
// ---------------------------------------------------------------------------
// rf_wport_arb_if
// Bundles the signals between the three writeback sources and the
// register-file write-port arbiter.
//
// Signals:
//   req[2:0]          per-source write request (0 = ALU, 1 = load, 2 = MDU)
//   addr0..addr2      destination register of each source
//   data0..data2      write data of each source
//   hold              pipeline freeze, suppresses all grants
//   clr_cnt           synchronous clear of conflict_cnt
//   gnt[2:0]          one-hot combinational grant back to the sources
//   sel[1:0]          registered writeback mux select
//   rf_we             registered register-file write enable
//   rf_addr[4:0]      registered write address
//   rf_data[31:0]     registered write data
//   conflict_cnt[7:0] saturating count of contended cycles
//
// Modports: slave = arbiter side, master = source/environment side.
// ---------------------------------------------------------------------------
interface rf_wport_arb_if;
    logic [2:0]  req;
    logic [4:0]  addr0;
    logic [4:0]  addr1;
    logic [4:0]  addr2;
    logic [31:0] data0;
    logic [31:0] data1;
    logic [31:0] data2;
    logic        hold;
    logic        clr_cnt;
    logic [2:0]  gnt;
    logic [1:0]  sel;
    logic        rf_we;
    logic [4:0]  rf_addr;
    logic [31:0] rf_data;
    logic [7:0]  conflict_cnt;

    modport slave (
        input  req, addr0, addr1, addr2, data0, data1, data2, hold, clr_cnt,
        output gnt, sel, rf_we, rf_addr, rf_data, conflict_cnt
    );

    modport master (
        output req, addr0, addr1, addr2, data0, data1, data2, hold, clr_cnt,
        input  gnt, sel, rf_we, rf_addr, rf_data, conflict_cnt
    );
endinterface

// File: rtl/rf_wport_arb.sv
// ---------------------------------------------------------------------------
// rf_wport_arb
// Round-robin arbiter for a single register-file write port shared by the
// ALU (source 0), the load unit (source 1) and the MDU (source 2).
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-low reset
//   bus    rf_wport_arb_if.slave: requests, addresses and data in; one-hot
//          combinational grant, registered writeback (sel, rf_we, rf_addr,
//          rf_data) and the saturating conflict counter out.
//
// The granted source's address/data are captured on the edge that completes
// the transfer, so the write appears at the register file one cycle later.
// Writes to register 0 are consumed like any other write but leave rf_we low.
// ---------------------------------------------------------------------------
module rf_wport_arb (
    input  logic          clk,
    input  logic          reset,
    rf_wport_arb_if.slave bus
);

    // ptr holds the index of the last granted source; 2 after reset so that
    // source 0 is first in line.
    localparam logic [1:0] PTR_RESET = 2'd2;
    localparam logic [7:0] CNT_MAX   = 8'hFF;

    logic [1:0]  ptr_q, ptr_d;
    logic [1:0]  sel_q, sel_d;
    logic        rf_we_q, rf_we_d;
    logic [4:0]  rf_addr_q, rf_addr_d;
    logic [31:0] rf_data_q, rf_data_d;
    logic [7:0]  cnt_q, cnt_d;

    logic [1:0]  prio0, prio1, prio2;
    logic [1:0]  gnt_idx;
    logic        xfer;
    logic [4:0]  win_addr;
    logic [31:0] win_data;
    logic        contended;

    // Priority order starts just after the last winner: ptr+1, ptr+2, ptr.
    always_comb begin
        case (ptr_q)
            2'd0:    {prio0, prio1, prio2} = {2'd1, 2'd2, 2'd0};
            2'd1:    {prio0, prio1, prio2} = {2'd2, 2'd0, 2'd1};
            default: {prio0, prio1, prio2} = {2'd0, 2'd1, 2'd2};
        endcase
    end

    // No grant while in reset or frozen; otherwise the first requester in
    // priority order wins.
    always_comb begin
        gnt_idx = 2'd0;
        xfer    = 1'b0;
        if (reset && !bus.hold) begin
            if (bus.req[prio0]) begin
                gnt_idx = prio0;
                xfer    = 1'b1;
            end else if (bus.req[prio1]) begin
                gnt_idx = prio1;
                xfer    = 1'b1;
            end else if (bus.req[prio2]) begin
                gnt_idx = prio2;
                xfer    = 1'b1;
            end
        end
    end

    always_comb begin
        case (gnt_idx)
            2'd0:    begin win_addr = bus.addr0; win_data = bus.data0; end
            2'd1:    begin win_addr = bus.addr1; win_data = bus.data1; end
            default: begin win_addr = bus.addr2; win_data = bus.data2; end
        endcase
    end

    // Two or more simultaneous requests count as a contended cycle.
    assign contended = (bus.req[0] & bus.req[1]) |
                       (bus.req[0] & bus.req[2]) |
                       (bus.req[1] & bus.req[2]);

    always_comb begin
        ptr_d     = ptr_q;
        sel_d     = sel_q;
        rf_addr_d = rf_addr_q;
        rf_data_d = rf_data_q;
        rf_we_d   = 1'b0;
        if (xfer) begin
            ptr_d     = gnt_idx;
            sel_d     = gnt_idx;
            rf_addr_d = win_addr;
            rf_data_d = win_data;
            rf_we_d   = (win_addr != 5'd0);
        end
    end

    // Clear wins over increment; the counter sticks at its maximum.
    always_comb begin
        cnt_d = cnt_q;
        if (bus.clr_cnt) begin
            cnt_d = 8'd0;
        end else if (!bus.hold && contended && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_q     <= PTR_RESET;
            sel_q     <= 2'd0;
            rf_we_q   <= 1'b0;
            rf_addr_q <= 5'd0;
            rf_data_q <= 32'd0;
            cnt_q     <= 8'd0;
        end else begin
            ptr_q     <= ptr_d;
            sel_q     <= sel_d;
            rf_we_q   <= rf_we_d;
            rf_addr_q <= rf_addr_d;
            rf_data_q <= rf_data_d;
            cnt_q     <= cnt_d;
        end
    end

    assign bus.gnt          = xfer ? (3'b001 << gnt_idx) : 3'b000;
    assign bus.sel          = sel_q;
    assign bus.rf_we        = rf_we_q;
    assign bus.rf_addr      = rf_addr_q;
    assign bus.rf_data      = rf_data_q;
    assign bus.conflict_cnt = cnt_q;

endmodule

// File: tb/tb_rf_wport_arb.sv
// ---------------------------------------------------------------------------
// tb_rf_wport_arb
// Scoreboard bench for rf_wport_arb. Each driven cycle pushes the expected
// grant and the expected visible register outputs for that cycle; a monitor
// on the falling edge pops and compares. Expected values come from a
// round-robin reference model kept in plain integers.
// ---------------------------------------------------------------------------
module tb_rf_wport_arb;

    typedef struct {
        logic [2:0]  gnt;
        logic [1:0]  sel;
        logic        we;
        logic [4:0]  addr;
        logic [31:0] data;
        logic [7:0]  cnt;
    } exp_t;

    logic clk;
    logic reset;

    rf_wport_arb_if bus();

    rf_wport_arb dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model: last winner, contention count and the write-port
    // registers as they should currently appear.
    int          m_ptr  = 2;
    int          m_cnt  = 0;
    logic [1:0]  m_sel  = 2'd0;
    logic        m_we   = 1'b0;
    logic [4:0]  m_addr = 5'd0;
    logic [31:0] m_data = 32'd0;
    int          last_win = -1;

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t",
                     name, act, expv, $time);
        end
    endtask

    function automatic int model_winner(input logic [2:0] r, input bit h);
        int idx;
        if (h) return -1;
        for (int k = 1; k <= 3; k++) begin
            idx = (m_ptr + k) % 3;
            if (r[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_ptr  = 2;
        m_cnt  = 0;
        m_sel  = 2'd0;
        m_we   = 1'b0;
        m_addr = 5'd0;
        m_data = 32'd0;
    endtask

    // Drives one cycle of inputs just after the rising edge, records what
    // the DUT should show during this cycle, then advances the model across
    // the next edge.
    task automatic applyStimulus(input logic [2:0] r,
                                 input logic [4:0] a0, input logic [4:0] a1,
                                 input logic [4:0] a2,
                                 input logic [31:0] d0, input logic [31:0] d1,
                                 input logic [31:0] d2,
                                 input bit h, input bit c);
        exp_t        e;
        int          w;
        logic [4:0]  wa;
        logic [31:0] wd;
        @(posedge clk);
        #1;
        bus.req = r;
        bus.addr0 = a0; bus.addr1 = a1; bus.addr2 = a2;
        bus.data0 = d0; bus.data1 = d1; bus.data2 = d2;
        bus.hold = h;
        bus.clr_cnt = c;
        w = model_winner(r, h);
        e.gnt  = (w < 0) ? 3'b000 : 3'(1 << w);
        e.sel  = m_sel;
        e.we   = m_we;
        e.addr = m_addr;
        e.data = m_data;
        e.cnt  = 8'(m_cnt);
        exp_q.push_back(e);
        if (w >= 0) begin
            wa = (w == 0) ? a0 : (w == 1) ? a1 : a2;
            wd = (w == 0) ? d0 : (w == 1) ? d1 : d2;
            m_ptr  = w;
            m_sel  = 2'(w);
            m_addr = wa;
            m_data = wd;
            m_we   = (wa != 5'd0);
        end else begin
            m_we = 1'b0;
        end
        if (c) m_cnt = 0;
        else if (!h && $countones(r) >= 2 && m_cnt < 255) m_cnt++;
        last_win = w;
    endtask

    task automatic idle();
        applyStimulus(3'b000, 0, 0, 0, 0, 0, 0, 1'b0, 1'b0);
    endtask

    // Pulses reset between edges and checks that outputs clear at once.
    task automatic do_reset();
        @(negedge clk);
        #1;
        reset = 1'b0;
        bus.req = 3'b000;
        bus.hold = 1'b0;
        bus.clr_cnt = 1'b0;
        #1;
        checkOutput("rst_we",   32'(bus.rf_we), 32'd0);
        checkOutput("rst_cnt",  32'(bus.conflict_cnt), 32'd0);
        checkOutput("rst_gnt",  32'(bus.gnt), 32'd0);
        checkOutput("rst_sel",  32'(bus.sel), 32'd0);
        checkOutput("rst_addr", 32'(bus.rf_addr), 32'd0);
        checkOutput("rst_data", bus.rf_data, 32'd0);
        #1;
        reset = 1'b1;
        model_reset();
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checkOutput("gnt",  32'(bus.gnt), 32'(e.gnt));
            checkOutput("sel",  32'(bus.sel), 32'(e.sel));
            checkOutput("we",   32'(bus.rf_we), 32'(e.we));
            checkOutput("addr", 32'(bus.rf_addr), 32'(e.addr));
            checkOutput("data", bus.rf_data, e.data);
            checkOutput("cnt",  32'(bus.conflict_cnt), 32'(e.cnt));
        end
    end

    logic [2:0]  pend;
    logic [4:0]  sa[3];
    logic [31:0] sd[3];

    initial begin
        bus.req = 3'b111;
        bus.addr0 = 5'd1; bus.addr1 = 5'd2; bus.addr2 = 5'd3;
        bus.data0 = 32'd0; bus.data1 = 32'd0; bus.data2 = 32'd0;
        bus.hold = 1'b0;
        bus.clr_cnt = 1'b0;
        reset = 1'b1;
        #1 reset = 1'b0;
        #2;
        checkOutput("init_gnt", 32'(bus.gnt), 32'd0);
        checkOutput("init_we",  32'(bus.rf_we), 32'd0);
        checkOutput("init_cnt", 32'(bus.conflict_cnt), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("inrst_gnt", 32'(bus.gnt), 32'd0);
        do_reset();

        // Single source write
        applyStimulus(3'b001, 5'd5, 0, 0, 32'h1234, 0, 0, 1'b0, 1'b0);
        idle();

        // Three-way contention from reset: 0, 1, 2 in turn
        do_reset();
        repeat (3) applyStimulus(3'b111, 5'd1, 5'd2, 5'd3,
                                 32'hA, 32'hB, 32'hC, 1'b0, 1'b0);
        idle();

        // Write to register 0 is consumed without enabling the write
        applyStimulus(3'b010, 0, 5'd0, 0, 0, 32'hDEAD, 0, 1'b0, 1'b0);
        idle();

        // Hold freezes arbitration; release goes to source 0
        do_reset();
        repeat (4) applyStimulus(3'b101, 5'd7, 0, 5'd9,
                                 32'h70, 0, 32'h90, 1'b1, 1'b0);
        applyStimulus(3'b101, 5'd7, 0, 5'd9, 32'h70, 0, 32'h90, 1'b0, 1'b0);
        idle();

        // Counter saturation then clear beating a contended increment
        repeat (300) applyStimulus(3'b111, 5'd4, 5'd5, 5'd6,
                                   32'h4, 32'h5, 32'h6, 1'b0, 1'b0);
        idle();
        applyStimulus(3'b111, 5'd4, 5'd5, 5'd6, 32'h4, 32'h5, 32'h6,
                      1'b0, 1'b1);
        idle();

        // Asynchronous reset during a transfer
        applyStimulus(3'b111, 5'd8, 5'd9, 5'd10, 32'h8, 32'h9, 32'hA,
                      1'b0, 1'b0);
        applyStimulus(3'b011, 5'd8, 5'd9, 5'd10, 32'h8, 32'h9, 32'hA,
                      1'b0, 1'b0);
        do_reset();
        applyStimulus(3'b111, 5'd11, 5'd12, 5'd13, 32'hB, 32'hC, 32'hD,
                      1'b0, 1'b0);
        idle();

        // Randomized traffic obeying the hold-until-granted handshake
        pend = 3'b000;
        for (int i = 0; i < 3; i++) begin
            sa[i] = 5'd0;
            sd[i] = 32'd0;
        end
        for (int n = 0; n < 2000; n++) begin
            for (int i = 0; i < 3; i++) begin
                if (!pend[i] && $urandom_range(0, 2) == 0) begin
                    pend[i] = 1'b1;
                    sa[i] = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
                    sd[i] = $urandom;
                end
            end
            applyStimulus(pend, sa[0], sa[1], sa[2], sd[0], sd[1], sd[2],
                          ($urandom_range(0, 6) == 0),
                          ($urandom_range(0, 40) == 0));
            if (last_win >= 0) pend[last_win] = 1'b0;
        end
        idle();

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("[TB] FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
